// File: rtl/xor_parity_pkg.sv
// rtl/xor_parity_pkg.sv - shared types and constants for the xor_parity_arbiter slice
package xor_parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/parity_shift_core.sv
// rtl/parity_shift_core.sv - shift register, down-counter and 1-bit XOR accumulator
// acc presents the running reduction with the current head bit already folded in.
module parity_shift_core
  import xor_parity_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift_en,
  output logic             last_bit,
  output logic             acc
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic             acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      count <= '0;
      acc_q <= 1'b0;
    end else if (load) begin
      sreg  <= data;
      count <= CW'(WIDTH);
      acc_q <= 1'b0;
    end else if (shift_en) begin
      acc_q <= acc_q ^ sreg[0];
      sreg  <= sreg >> 1;
      // Counter parks at 1 rather than wrapping.
      if (count > CW'(1)) count <= count - CW'(1);
    end
  end

  assign last_bit = (count == CW'(1));
  assign acc      = acc_q ^ sreg[0];

endmodule

// File: rtl/xor_parity_arbiter.sv
// rtl/xor_parity_arbiter.sv - round-robin shared bit-serial parity engine (top)
// Optional macro XOR_PARITY_ODD_EN selects odd parity on the parity output.
module xor_parity_arbiter
  import xor_parity_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             parity,
  output logic             done_id
);

`ifdef XOR_PARITY_ODD_EN
  localparam logic PARITY_FLIP = 1'b1;
`else
  localparam logic PARITY_FLIP = 1'b0;
`endif

  state_t           state, next_state;
  logic             last, last_d;
  logic             winner;
  logic [WIDTH-1:0] win_data;
  logic             load, shift_en, last_bit, acc;
  logic             gnt0_d, gnt1_d, busy_d, done_d, parity_d, done_id_d;

  // Round-robin: on a tie the requester not served last time wins.
  always_comb begin
    winner = REQ0;
    if (req0 && req1) winner = ~last;
    else if (req1)    winner = REQ1;
    win_data = (winner == REQ1) ? data1 : data0;
  end

  assign load     = (state == IDLE) && (req0 || req1);
  assign shift_en = (state == SHIFT);

  parity_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data     (win_data),
    .shift_en (shift_en),
    .last_bit (last_bit),
    .acc      (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= REQ1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      parity  <= 1'b0;
      done_id <= 1'b0;
    end else begin
      state   <= next_state;
      last    <= last_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      busy    <= busy_d;
      done    <= done_d;
      parity  <= parity_d;
      done_id <= done_id_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req0 || req1) next_state = SHIFT;
      SHIFT:   if (last_bit)     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gnt0_d    = load && (winner == REQ0);
    gnt1_d    = load && (winner == REQ1);
    busy_d    = (next_state != IDLE);
    done_d    = (next_state == DONE);
    last_d    = load ? winner : last;
    parity_d  = parity;
    done_id_d = done_id;
    // Capture on the final shift edge so parity is valid in the DONE cycle.
    if (state == SHIFT && last_bit) begin
      parity_d  = acc ^ PARITY_FLIP;
      done_id_d = last;
    end
  end

endmodule
